// File: rtl/rx_sched_pkg.sv
// Shared types for the frame-level ingress scheduler.
package rx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester above 'last', wrapping.
module rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  logic [ID_W-1:0] w_idx;

  // Walk from the farthest candidate down so the nearest one above 'last' wins.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int k = int'(N_SRC); k >= 1; k--) begin
      w_idx = ID_W'((int'(last) + k) % int'(N_SRC));
      if (req[w_idx]) begin
        gnt_id = w_idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_frame_sched.sv
// Shares one byte-stream ingress among N_SRC sources, one whole frame per grant,
// with a minimum inter-frame gap and stall abort.
module rx_frame_sched
  import rx_sched_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned IFG       = 2,
  parameter int unsigned STALL_MAX = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [8*N_SRC-1:0]       src_data,
  input  logic [N_SRC-1:0]         src_last,
  output logic [N_SRC-1:0]         src_ready,
  output logic [7:0]               rxd,
  output logic                     rx_dv,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     busy,
  output logic                     abort,
  output logic [CNT_W-1:0]         frames_sent
);

  localparam int unsigned ID_W = $clog2(N_SRC);
  localparam int unsigned SW   = $clog2(STALL_MAX + 1);
  localparam int unsigned GW   = $clog2(IFG + 1);

  state_t          r_state;
  logic [ID_W-1:0] r_last_grant;
  logic [SW-1:0]   r_stall_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic [ID_W-1:0] w_pick_id;
  logic            w_pick_any;
  logic            w_sel_valid;
  logic            w_sel_last;
  byte_t           w_sel_data;

  rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (src_valid),
    .last   (r_last_grant),
    .gnt_id (w_pick_id),
    .any    (w_pick_any)
  );

  assign w_sel_valid = src_valid[grant_id];
  assign w_sel_last  = src_last[grant_id];
  assign w_sel_data  = src_data[{grant_id, 3'b000} +: 8];

  always_comb begin
    src_ready = '0;
    if (r_state == XFER) src_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(N_SRC - 1);
      r_stall_cnt  <= '0;
      r_gap_cnt    <= '0;
      rxd          <= '0;
      rx_dv        <= 1'b0;
      grant_id     <= '0;
      busy         <= 1'b0;
      abort        <= 1'b0;
      frames_sent  <= '0;
    end else begin
      abort <= 1'b0;
      rx_dv <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            grant_id     <= w_pick_id;
            r_last_grant <= w_pick_id;
            r_stall_cnt  <= '0;
            r_state      <= XFER;
            busy         <= 1'b1;
          end
        end
        XFER: begin
          if (w_sel_valid) begin
            rxd         <= w_sel_data;
            rx_dv       <= 1'b1;
            r_stall_cnt <= '0;
            if (w_sel_last) begin
              frames_sent <= frames_sent + 1'b1;
              r_gap_cnt   <= '0;
              r_state     <= GAP;
            end
          end else if (r_stall_cnt == SW'(STALL_MAX - 1)) begin
            // Partial frame is abandoned; its remaining bytes re-arbitrate later.
            abort       <= 1'b1;
            r_stall_cnt <= '0;
            r_gap_cnt   <= '0;
            r_state     <= GAP;
          end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GW'(IFG - 1)) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
